// File: rtl/oled_text_ctrl.sv
// Text-mode controller for an SPI OLED panel: power sequencing, init commands, glyph streaming.
// Define OLED_CLEAR_EN to add the clear_req input and the full-screen CLEAR state.
module oled_text_ctrl #(
    parameter int unsigned CLK_DIV   = 5,
    parameter int unsigned PAGES     = 4,
    parameter int unsigned COLS      = 128,
    parameter int unsigned GLYPH_W   = 8,
    parameter int unsigned PWR_DELAY = 2000000,
    parameter logic [7:0]  COM_CFG   = 8'h02,
    localparam int unsigned PW       = (PAGES > 1) ? $clog2(PAGES) : 1
) (
`ifdef OLED_CLEAR_EN
    input  logic          clear_req,
`endif
    input  logic          clock,
    input  logic          reset_n,
    output logic          oled_spi_clk,
    output logic          oled_spi_data,
    output logic          oled_vdd,
    output logic          oled_vbat,
    output logic          oled_reset_n,
    output logic          oled_dc_n,
    input  logic [6:0]    char_code,
    input  logic          char_valid,
    output logic          char_ready,
    output logic [6:0]    glyph_code,
    output logic [2:0]    glyph_col,
    input  logic [7:0]    glyph_byte,
    output logic          init_done,
    output logic [PW-1:0] cur_page,
    output logic [7:0]    cur_col
);

    localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TW   = $clog2(PWR_DELAY + 1);
    localparam int unsigned IW   = $clog2(COLS + 4);
    localparam int unsigned NCMD = 12;

    typedef enum logic [3:0] {
        PWR, DLY, CMD, RST, VBAT, READY, ADDR, GLYPH
`ifdef OLED_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t         state, state_nxt;
    logic [3:0]     cmd_idx;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  dly_cnt;
    logic           ready_q;
    logic [6:0]     code_q;

    logic           spi_busy, spi_done;
    logic [DW-1:0]  div_cnt;
    logic [3:0]     half_cnt;
    logic [7:0]     shreg;

    logic           spi_idle_c, spi_start_c, spi_dc_c;
    logic [7:0]     spi_byte_c;
    logic           dly_en_c, dly_done_c;
    logic           clear_go_c, accept_c, newline_c, col_wrap_c;
    logic [8:0]     col_sum_c;
    logic [PW-1:0]  page_inc_c;

`ifdef OLED_CLEAR_EN
    logic [PW-1:0]  clr_page;
    assign clear_go_c = (state == READY) && clear_req;
    assign char_ready = ready_q & ~clear_req;
`else
    assign clear_go_c = 1'b0;
    assign char_ready = ready_q;
`endif

    assign glyph_code = code_q;
    assign glyph_col  = idx[2:0];
    assign spi_idle_c = !spi_busy && !spi_done;
    assign accept_c   = (state == READY) && char_valid && ready_q && !clear_go_c;
    assign newline_c  = accept_c && (char_code == 7'h0A);
    assign col_sum_c  = {1'b0, cur_col} + 9'(GLYPH_W);
    assign col_wrap_c = col_sum_c > 9'(COLS - GLYPH_W);
    assign page_inc_c = (cur_page == PW'(PAGES - 1)) ? '0 : cur_page + PW'(1);
    assign dly_done_c = dly_en_c && (dly_cnt == TW'(PWR_DELAY - 1));

    // Panel init command table, walked by cmd_idx across the power sequence
    function automatic logic [7:0] init_cmd(input logic [3:0] i);
        case (i)
            4'd0:    return 8'hAE;
            4'd1:    return 8'h8D;
            4'd2:    return 8'h14;
            4'd3:    return 8'hD9;
            4'd4:    return 8'hF1;
            4'd5:    return 8'h81;
            4'd6:    return 8'hFF;
            4'd7:    return 8'hA0;
            4'd8:    return 8'hC0;
            4'd9:    return 8'hDA;
            4'd10:   return COM_CFG;
            default: return 8'hAF;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= PWR;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PWR:   state_nxt = DLY;
            DLY:   if (dly_done_c) state_nxt = CMD;
            CMD: begin
                if (spi_done) begin
                    if (cmd_idx == 4'd0)                 state_nxt = RST;
                    else if (cmd_idx == 4'd4)            state_nxt = VBAT;
                    else if (cmd_idx == 4'(NCMD - 1))    state_nxt = READY;
                end
            end
            RST:   if (dly_done_c && idx != '0) state_nxt = CMD;
            VBAT:  if (dly_done_c) state_nxt = CMD;
            READY: begin
`ifdef OLED_CLEAR_EN
                if (clear_go_c) state_nxt = CLEAR;
                else
`endif
                if (accept_c && !newline_c) state_nxt = ADDR;
            end
            ADDR:  if (spi_done && idx == IW'(2)) state_nxt = GLYPH;
            GLYPH: if (spi_done && idx == IW'(GLYPH_W - 1)) state_nxt = READY;
`ifdef OLED_CLEAR_EN
            CLEAR: if (spi_done && idx == IW'(COLS + 2) && clr_page == PW'(PAGES - 1))
                       state_nxt = READY;
`endif
            default: state_nxt = PWR;
        endcase
    end

    // Byte source and delay enable for the current state
    always_comb begin
        spi_start_c = 1'b0;
        spi_byte_c  = 8'h00;
        spi_dc_c    = 1'b0;
        dly_en_c    = 1'b0;
        case (state)
            DLY, RST, VBAT: dly_en_c = 1'b1;
            CMD: begin
                spi_start_c = spi_idle_c;
                spi_byte_c  = init_cmd(cmd_idx);
            end
            ADDR: begin
                spi_start_c = spi_idle_c;
                if (idx == '0)           spi_byte_c = 8'hB0 | 8'(cur_page);
                else if (idx == IW'(1))  spi_byte_c = {4'h0, cur_col[3:0]};
                else                     spi_byte_c = {4'h1, cur_col[7:4]};
            end
            GLYPH: begin
                spi_start_c = spi_idle_c;
                spi_byte_c  = glyph_byte;
                spi_dc_c    = 1'b1;
            end
`ifdef OLED_CLEAR_EN
            CLEAR: begin
                spi_start_c = spi_idle_c;
                if (idx == '0)          spi_byte_c = 8'hB0 | 8'(clr_page);
                else if (idx == IW'(2)) spi_byte_c = 8'h10;
                else                    spi_byte_c = 8'h00;
                spi_dc_c = idx > IW'(2);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            oled_vdd     <= 1'b1;
            oled_vbat    <= 1'b1;
            oled_reset_n <= 1'b1;
            init_done    <= 1'b0;
            ready_q      <= 1'b0;
            cur_page     <= '0;
            cur_col      <= '0;
            cmd_idx      <= '0;
            idx          <= '0;
            dly_cnt      <= '0;
            code_q       <= '0;
`ifdef OLED_CLEAR_EN
            clr_page     <= '0;
`endif
        end else begin
            dly_cnt      <= (dly_en_c && !dly_done_c) ? dly_cnt + TW'(1) : '0;
            ready_q      <= (state_nxt == READY) && !accept_c;
            oled_reset_n <= !(state == RST && idx == '0);
            if (state == PWR)          oled_vdd  <= 1'b0;
            if (state == VBAT)         oled_vbat <= 1'b0;
            if (state_nxt == READY)    init_done <= 1'b1;
            if (state == CMD && spi_done) cmd_idx <= cmd_idx + 4'd1;
            if (accept_c)              code_q    <= char_code;

            // idx: per-state byte / phase counter, cleared on every state change
            if (state_nxt != state)                idx <= '0;
            else if (state == RST && dly_done_c)   idx <= idx + IW'(1);
            else if (spi_done) begin
`ifdef OLED_CLEAR_EN
                if (state == CLEAR && idx == IW'(COLS + 2)) idx <= '0;
                else
`endif
                idx <= idx + IW'(1);
            end

            if (newline_c) begin
                cur_col  <= '0;
                cur_page <= page_inc_c;
            end else if (state == GLYPH && state_nxt == READY) begin
                if (col_wrap_c) begin
                    cur_col  <= '0;
                    cur_page <= page_inc_c;
                end else begin
                    cur_col  <= col_sum_c[7:0];
                end
            end
`ifdef OLED_CLEAR_EN
            else if (state == CLEAR && state_nxt == READY) begin
                cur_col  <= '0;
                cur_page <= '0;
            end
            if (state == READY)
                clr_page <= '0;
            else if (state == CLEAR && spi_done && idx == IW'(COLS + 2))
                clr_page <= clr_page + PW'(1);
`endif
        end
    end

    // SPI shifter: clock idles high, data moves on falling edges, 16 half-periods per byte
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spi_busy      <= 1'b0;
            spi_done      <= 1'b0;
            div_cnt       <= '0;
            half_cnt      <= '0;
            shreg         <= '0;
            oled_spi_clk  <= 1'b1;
            oled_spi_data <= 1'b0;
            oled_dc_n     <= 1'b0;
        end else begin
            spi_done <= 1'b0;
            if (spi_start_c) begin
                spi_busy      <= 1'b1;
                div_cnt       <= '0;
                half_cnt      <= '0;
                oled_spi_clk  <= 1'b0;
                oled_spi_data <= spi_byte_c[7];
                shreg         <= {spi_byte_c[6:0], 1'b0};
                oled_dc_n     <= spi_dc_c;
            end else if (spi_busy) begin
                if (div_cnt == DW'(CLK_DIV - 1)) begin
                    div_cnt <= '0;
                    if (half_cnt == 4'd15) begin
                        spi_busy     <= 1'b0;
                        spi_done     <= 1'b1;
                        oled_spi_clk <= 1'b1;
                    end else begin
                        half_cnt     <= half_cnt + 4'd1;
                        oled_spi_clk <= ~oled_spi_clk;
                        if (oled_spi_clk) begin
                            oled_spi_data <= shreg[7];
                            shreg         <= {shreg[6:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_oled_text_ctrl.sv
// Self-checking bench for oled_text_ctrl: decodes the SPI stream and compares it with a cursor/glyph model.
// Build with OLED_CLEAR_EN defined to also exercise the clear path.
module tb_oled_text_ctrl;

    localparam int unsigned CLK_DIV   = 1;
    localparam int unsigned PAGES     = 4;
    localparam int unsigned COLS      = 128;
    localparam int unsigned GLYPH_W   = 8;
    localparam int unsigned PWR_DELAY = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       oled_spi_clk, oled_spi_data, oled_vdd, oled_vbat, oled_reset_n, oled_dc_n;
    logic [6:0] char_code = 7'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic [6:0] glyph_code;
    logic [2:0] glyph_col;
    logic [7:0] glyph_byte;
    logic       init_done;
    logic [1:0] cur_page;
    logic [7:0] cur_col;
`ifdef OLED_CLEAR_EN
    logic       clear_req = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    oled_text_ctrl #(
        .CLK_DIV(CLK_DIV), .PAGES(PAGES), .COLS(COLS), .GLYPH_W(GLYPH_W),
        .PWR_DELAY(PWR_DELAY), .COM_CFG(8'h02)
    ) dut (
`ifdef OLED_CLEAR_EN
        .clear_req(clear_req),
`endif
        .clock(clock), .reset_n(reset_n),
        .oled_spi_clk(oled_spi_clk), .oled_spi_data(oled_spi_data),
        .oled_vdd(oled_vdd), .oled_vbat(oled_vbat),
        .oled_reset_n(oled_reset_n), .oled_dc_n(oled_dc_n),
        .char_code(char_code), .char_valid(char_valid), .char_ready(char_ready),
        .glyph_code(glyph_code), .glyph_col(glyph_col), .glyph_byte(glyph_byte),
        .init_done(init_done), .cur_page(cur_page), .cur_col(cur_col)
    );

    // Glyph ROM stand-in: any fixed function of (code, column)
    function automatic logic [7:0] rom(input logic [6:0] c, input logic [2:0] k);
        return ({1'b0, c} + 8'(k) * 8'd37) ^ 8'hA5;
    endfunction
    assign glyph_byte = rom(glyph_code, glyph_col);

    // SPI decoder: panel samples on rising edge, bytes stored as {dc_n, data}
    logic [8:0] byte_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] sh;
    logic       dc0;
    int nbits = 0;
    int dc_glitch = 0;
    int vbat_at = -1;
    int rst_at = -1;

    always @(posedge oled_spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            nbits = 0;
        end else begin
            if (nbits == 0) dc0 = oled_dc_n;
            else if (oled_dc_n !== dc0) dc_glitch++;
            sh = {sh[6:0], oled_spi_data};
            nbits++;
            if (nbits == 8) begin
                byte_q.push_back({dc0, sh});
                nbits = 0;
            end
        end
    end
    always @(negedge oled_vbat)    vbat_at = byte_q.size();
    always @(negedge oled_reset_n) rst_at  = byte_q.size();

    logic [7:0] init_seq [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                  8'hFF, 8'hA0, 8'hC0, 8'hDA, 8'h02, 8'hAF};

    // Reference model: text cursor advancing glyph by glyph
    int m_page = 0;
    int m_col  = 0;

    task automatic model_char(input logic [6:0] code);
        if (code == 7'h0A) begin
            m_col  = 0;
            m_page = (m_page + 1) % PAGES;
        end else begin
            exp_q.push_back({1'b0, 8'hB0 + 8'(m_page)});
            exp_q.push_back({1'b0, 8'(m_col % 16)});
            exp_q.push_back({1'b0, 8'h10 + 8'(m_col / 16)});
            for (int k = 0; k < GLYPH_W; k++) exp_q.push_back({1'b1, rom(code, 3'(k))});
            if (m_col + GLYPH_W > COLS - GLYPH_W) begin
                m_col  = 0;
                m_page = (m_page + 1) % PAGES;
            end else begin
                m_col = m_col + GLYPH_W;
            end
        end
    endtask

    function automatic int first_diff();
        int n = (byte_q.size() < exp_q.size()) ? byte_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (byte_q[i] !== exp_q[i]) return i;
        if (byte_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [8:0] got_at(input int i);
        return (i >= 0 && i < byte_q.size()) ? byte_q[i] : 9'h1FF;
    endfunction
    function automatic logic [8:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 9'h1FF;
    endfunction

    task automatic drive_char(input logic [6:0] code, output bit ok);
        int cyc = 0;
        ok = 1'b0;
        @(negedge clock);
        while (char_ready !== 1'b1 && cyc < 5000) begin @(negedge clock); cyc++; end
        if (char_ready === 1'b1) begin
            char_code  = code;
            char_valid = 1'b1;
            @(posedge clock); #1;
            char_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic wait_ready(input int limit, output bit ok);
        int cyc = 0;
        @(negedge clock);
        while (char_ready !== 1'b1 && cyc < limit) begin @(negedge clock); cyc++; end
        ok = (char_ready === 1'b1);
    endtask

    task automatic wait_init(output bit ok);
        int cyc = 0;
        while (init_done !== 1'b1 && cyc < 5000) begin @(negedge clock); cyc++; end
        ok = (init_done === 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b1; #1;
        reset_n = 1'b0; #1;
        n_cmp++;
        if ({oled_vdd, oled_vbat, oled_reset_n, oled_dc_n, oled_spi_clk, oled_spi_data,
             char_ready, init_done} !== 8'b1110_1000) begin
            n_err++;
            $display("FAIL reset_outputs got=%b exp=%b", {oled_vdd, oled_vbat, oled_reset_n,
                     oled_dc_n, oled_spi_clk, oled_spi_data, char_ready, init_done}, 8'b1110_1000);
        end
        n_cmp++;
        if ({cur_page, cur_col} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_cursor got=%0d,%0d exp=0,0", cur_page, cur_col);
        end
        repeat (3) @(posedge clock);
    endtask

    task automatic test_powerup();
        bit ok;
        bit early = 1'b0;
        int d;
        byte_q.delete(); exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_seq[i]});
        vbat_at = -1; rst_at = -1;
        char_code = 7'h41; char_valid = 1'b1;
        @(negedge clock); reset_n = 1'b1;
        for (int cyc = 0; cyc < 5000 && init_done !== 1'b1; cyc++) begin
            @(negedge clock);
            if (char_ready === 1'b1 && init_done !== 1'b1) early = 1'b1;
        end
        char_valid = 1'b0;
        n_cmp++;
        if (init_done !== 1'b1) begin n_err++; $display("FAIL init_timeout got=%b exp=1", init_done); end
        d = first_diff();
        n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL init_bytes at=%0d got=%h exp=%h n=%0d/%0d", d, got_at(d), exp_at(d),
                     byte_q.size(), exp_q.size());
        end
        n_cmp++;
        if (vbat_at != 5) begin n_err++; $display("FAIL vbat_order got=%0d exp=5", vbat_at); end
        n_cmp++;
        if (rst_at != 1) begin n_err++; $display("FAIL panel_reset_order got=%0d exp=1", rst_at); end
        n_cmp++;
        if (early) begin n_err++; $display("FAIL ready_before_init got=1 exp=0"); end
        repeat (40) @(negedge clock);
        n_cmp++;
        if (byte_q.size() != 12 || char_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_after_init bytes=%0d ready=%b exp 12,1", byte_q.size(), char_ready);
        end
        ok = 1'b1;
    endtask

    task automatic test_one_char();
        bit ok;
        int d;
        byte_q.delete(); exp_q.delete();
        model_char(7'h41);
        drive_char(7'h41, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL char_accept got=0 exp=1"); end
        n_cmp++;
        if (char_ready !== 1'b0) begin n_err++; $display("FAIL ready_drop got=%b exp=0", char_ready); end
        wait_ready(2000, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL char_done_timeout got=0 exp=1"); end
        d = first_diff();
        n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL char_bytes at=%0d got=%h exp=%h", d, got_at(d), exp_at(d));
        end
        n_cmp++;
        if (dc_glitch != 0) begin n_err++; $display("FAIL dc_stable got=%0d exp=0", dc_glitch); end
        n_cmp++;
        if (cur_page !== 2'd0 || cur_col !== 8'd8) begin
            n_err++;
            $display("FAIL cursor_one got=%0d,%0d exp=0,8", cur_page, cur_col);
        end
    endtask

    task automatic test_wrap();
        bit ok, ok2;
        int d;
        logic [6:0] code;
        for (int n = 1; n < 64; n++) begin
            code = 7'($urandom_range(0, 127));
            if (code == 7'h0A) code = 7'h0B;
            byte_q.delete(); exp_q.delete();
            model_char(code);
            drive_char(code, ok);
            wait_ready(2000, ok2);
            d = first_diff();
            n_cmp++;
            if (!ok || !ok2 || d >= 0) begin
                n_err++;
                $display("FAIL wrap_char n=%0d code=%h at=%0d got=%h exp=%h acc=%b done=%b",
                         n, code, d, got_at(d), exp_at(d), ok, ok2);
            end
            if (n == 16) begin
                n_cmp++;
                if ({got_at(0), got_at(1), got_at(2)} !== {9'h0B1, 9'h000, 9'h010}) begin
                    n_err++;
                    $display("FAIL wrap_addr17 got=%h %h %h exp=0b1 000 010",
                             got_at(0), got_at(1), got_at(2));
                end
            end
        end
        n_cmp++;
        if (cur_page !== 2'd0 || cur_col !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_home got=%0d,%0d exp=0,0", cur_page, cur_col);
        end
    endtask

    task automatic test_newline();
        bit ok;
        int cyc;
        logic [6:0] code;
        for (int i = 0; i < 3; i++) begin
            model_char(7'h0A);
            drive_char(7'h0A, ok);
            wait_ready(100, ok);
        end
        n_cmp++;
        if (cur_page !== 2'(m_page) || cur_col !== 8'(m_col)) begin
            n_err++;
            $display("FAIL newline_x3 got=%0d,%0d exp=%0d,%0d", cur_page, cur_col, m_page, m_col);
        end
        for (int i = 0; i < 5; i++) begin
            code = 7'($urandom_range(32, 126));
            model_char(code);
            drive_char(code, ok);
            wait_ready(2000, ok);
        end
        n_cmp++;
        if (cur_page !== 2'd3 || cur_col !== 8'd40) begin
            n_err++;
            $display("FAIL newline_setup got=%0d,%0d exp=3,40", cur_page, cur_col);
        end
        byte_q.delete();
        model_char(7'h0A);
        drive_char(7'h0A, ok);
        cyc = 0;
        while (char_ready !== 1'b1 && cyc < 10) begin @(posedge clock); #1; cyc++; end
        n_cmp++;
        if (!ok || char_ready !== 1'b1 || cyc > 2) begin
            n_err++;
            $display("FAIL newline_ready got=%0d cycles exp<=2 (accepted=%b)", cyc, ok);
        end
        repeat (40) @(negedge clock);
        n_cmp++;
        if (byte_q.size() != 0) begin
            n_err++;
            $display("FAIL newline_no_spi got=%0d bytes exp=0", byte_q.size());
        end
        n_cmp++;
        if (cur_page !== 2'(m_page) || cur_col !== 8'(m_col) || m_page != 0 || m_col != 0) begin
            n_err++;
            $display("FAIL newline_cursor got=%0d,%0d exp=0,0", cur_page, cur_col);
        end
    endtask

    task automatic test_reset_mid_byte();
        bit ok;
        int cyc = 0;
        int d;
        byte_q.delete();
        drive_char(7'($urandom_range(32, 126)), ok);
        while ((byte_q.size() < 5 || oled_dc_n !== 1'b1 || oled_spi_clk !== 1'b0) && cyc < 2000) begin
            @(negedge clock); cyc++;
        end
        n_cmp++;
        if (oled_dc_n !== 1'b1 || oled_spi_clk !== 1'b0) begin
            n_err++;
            $display("FAIL glyph_phase_timeout dc=%b sclk=%b exp 1,0", oled_dc_n, oled_spi_clk);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({oled_vdd, oled_vbat, oled_reset_n, oled_dc_n, oled_spi_clk, oled_spi_data,
             char_ready, init_done, cur_page, cur_col} !== {8'b1110_1000, 10'd0}) begin
            n_err++;
            $display("FAIL midbyte_reset got=%b exp=%b", {oled_vdd, oled_vbat, oled_reset_n,
                     oled_dc_n, oled_spi_clk, oled_spi_data, char_ready, init_done, cur_page, cur_col},
                     {8'b1110_1000, 10'd0});
        end
        m_page = 0; m_col = 0;
        byte_q.delete(); exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_seq[i]});
        repeat (3) @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        cyc = 0;
        while (byte_q.size() < 1 && cyc < 2000) begin @(negedge clock); cyc++; end
        n_cmp++;
        if (got_at(0) !== 9'h0AE) begin
            n_err++;
            $display("FAIL first_after_reset got=%h exp=0ae", got_at(0));
        end
        wait_init(ok);
        d = first_diff();
        n_cmp++;
        if (!ok || d >= 0) begin
            n_err++;
            $display("FAIL reinit_bytes at=%0d got=%h exp=%h done=%b", d, got_at(d), exp_at(d), ok);
        end
    endtask

`ifdef OLED_CLEAR_EN
    task automatic test_clear();
        bit ok;
        int d;
        int cyc = 0;
        for (int i = 0; i < 3; i++) begin
            model_char(7'h21 + 7'(i));
            drive_char(7'h21 + 7'(i), ok);
            wait_ready(2000, ok);
        end
        byte_q.delete(); exp_q.delete();
        for (int p = 0; p < PAGES; p++) begin
            exp_q.push_back({1'b0, 8'hB0 + 8'(p)});
            exp_q.push_back(9'h000);
            exp_q.push_back(9'h010);
            for (int c = 0; c < COLS; c++) exp_q.push_back(9'h100);
        end
        @(negedge clock);
        while (char_ready !== 1'b1 && cyc < 100) begin @(negedge clock); cyc++; end
        clear_req = 1'b1; char_valid = 1'b1; char_code = 7'h41;
        #1;
        n_cmp++;
        if (char_ready !== 1'b0) begin n_err++; $display("FAIL clear_masks_ready got=%b exp=0", char_ready); end
        @(posedge clock); #1;
        clear_req = 1'b0; char_valid = 1'b0;
        wait_ready(20000, ok);
        d = first_diff();
        n_cmp++;
        if (!ok || d >= 0) begin
            n_err++;
            $display("FAIL clear_bytes at=%0d got=%h exp=%h n=%0d/%0d done=%b", d, got_at(d),
                     exp_at(d), byte_q.size(), exp_q.size(), ok);
        end
        n_cmp++;
        if (cur_page !== 2'd0 || cur_col !== 8'd0) begin
            n_err++;
            $display("FAIL clear_cursor got=%0d,%0d exp=0,0", cur_page, cur_col);
        end
        m_page = 0; m_col = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_powerup();
        test_one_char();
        test_wrap();
        test_newline();
        test_reset_mid_byte();
`ifdef OLED_CLEAR_EN
        test_clear();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/oled_text_ctrl.md
OLED_TEXT_CTRL -- requirements
Module: oled_text_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5, meaning system clocks per SPI half-period (10 MHz at 100 MHz).
REQ-002 SHALL have parameter PAGES, default 4, meaning display pages (4 = 32 rows, 8 = 64 rows).
REQ-003 SHALL have parameter COLS, default 128, meaning display columns.
REQ-004 SHALL have parameter GLYPH_W, default 8, meaning glyph width in columns (1..8).
REQ-005 SHALL have parameter PWR_DELAY, default 2000000, meaning clock cycles per power-sequencing delay.
REQ-006 SHALL have parameter COM_CFG, default 8'h02, meaning the byte sent after command DA.
REQ-007 SHALL have port clock, input, 1, the system clock.
REQ-008 SHALL have port reset_n, input, 1: reset is asynchronous and active-low.
REQ-009 SHALL have ports oled_spi_clk and oled_spi_data, outputs, 1 each: the SPI link to the panel.
REQ-010 SHALL have ports oled_vdd, oled_vbat, oled_reset_n and oled_dc_n, outputs, 1 each: panel power and control (vdd and vbat: 0 = on).
REQ-011 SHALL have port char_code, input, 7: the character to draw.
REQ-012 SHALL have ports char_valid, input, 1, and char_ready, output, 1: the character handshake.
REQ-013 SHALL have ports glyph_code, output, 7, and glyph_col, output, 3: the external glyph ROM address.
REQ-014 SHALL have port glyph_byte, input, 8: glyph column data, combinational, valid in the same cycle as the address.
REQ-015 SHALL have port init_done, output, 1: high once panel initialisation is complete.
REQ-016 SHALL have ports cur_page, output, clog2(PAGES), and cur_col, output, 8: the cursor position.
REQ-017 SHALL have port clear_req, input, 1, present only when the macro in REQ-036 is defined.

Function
REQ-018 SHALL include an SPI shifter with these properties:
- 8 bits per byte, MSB first.
- oled_spi_clk idles high; data changes on the falling edge.
- One byte takes 16*CLK_DIV cycles.
- oled_dc_n is held stable for the whole byte.
REQ-019 SHALL include an internal delay counter of PWR_DELAY cycles.
REQ-020 SHALL run the following power-up sequence, each delay being PWR_DELAY cycles:
- set oled_vdd=0, then delay;
- send command AE;
- drive oled_reset_n=0, delay, drive oled_reset_n=1, delay;
- send commands 8D 14 D9 F1;
- set oled_vbat=0, then delay;
- send commands 81 FF A0 C0 DA COM_CFG AF;
- enter READY with init_done=1.
REQ-021 SHALL send all init commands with oled_dc_n=0, taken from an indexed command table (no per-byte states).
REQ-022 SHALL use the FSM states PWR, DLY, CMD, RST, VBAT, READY, ADDR, GLYPH and CLEAR.
REQ-023 SHALL drive char_ready=1 only in READY, and force it to 0 while clear_req=1.
REQ-024 SHALL accept a character on the cycle where char_valid=1 and char_ready=1, latch char_code, and drop char_ready in the next cycle.
REQ-025 SHALL send three address bytes on acceptance (dc_n=0):
- B0|cur_page;
- 00|cur_col[3:0];
- 10|cur_col[7:4].
REQ-026 SHALL then send GLYPH_W data bytes glyph_byte at glyph_col 0..GLYPH_W-1 (dc_n=1), with glyph_code equal to the latched code.
REQ-027 SHALL, after the last byte, advance cur_col by GLYPH_W and return to READY.
- If cur_col+GLYPH_W > COLS-GLYPH_W: cur_col=0 and cur_page=(cur_page+1) mod PAGES.
- Page PAGES-1 wraps to page 0.
REQ-028 SHALL treat char_code 7'h0A as newline: no SPI traffic, cur_col=0, cur_page increments modulo PAGES, char_ready high again within 2 cycles.
REQ-029 SHALL ignore char_valid while init_done=0.

Reset
REQ-030 SHALL, on reset_n=0, immediately set:
- oled_vdd=1, oled_vbat=1, oled_reset_n=1, oled_dc_n=0;
- oled_spi_clk=1, oled_spi_data=0;
- char_ready=0, init_done=0;
- cur_page=0, cur_col=0;
- FSM=PWR.
REQ-031 SHALL abort any byte in progress on reset assertion mid-operation; no partial byte resumes.
REQ-032 SHALL restart the full power-up sequence of REQ-020 on reset release.
REQ-033 SHALL keep every register on reset_n only; no synchronous reset.

Configuration
REQ-034 SHALL, with OLED_CLEAR_EN defined, accept clear_req=1 in READY.
REQ-035 SHALL, on an accepted clear, write 0x00 to all PAGES*COLS bytes (B0|page, 00, 10, then COLS zero bytes per page), set cursor to 0,0 and return to READY.
REQ-036 SHALL, with OLED_CLEAR_EN defined, give clear_req priority over a simultaneous char_valid; the character is not accepted.
REQ-037 SHALL, with OLED_CLEAR_EN undefined, omit the clear_req port and the CLEAR state entirely.

Verification
REQ-038 SHALL cover power-up (CLK_DIV=1, PWR_DELAY=16): release reset -> decoded SPI bytes AE 8D 14 D9 F1 81 FF A0 C0 DA 02 AF in order, with vbat falling after F1 and init_done=1 after AF.
REQ-039 SHALL cover one character: char_code=7'h41 accepted at cursor 0,0 -> bytes B0 00 10 then 8 glyph bytes with dc_n=1 -> cur_col=8.
REQ-040 SHALL cover wrap: 16 characters with PAGES=4 -> the 17th is addressed B1 00 10; after 64 characters the cursor returns to page 0, col 0.
REQ-041 SHALL cover newline: 7'h0A at col 40, page 3 -> no SPI bytes, cursor 0,0.
REQ-042 SHALL cover reset mid-byte: reset_n low during a glyph byte -> all outputs at REQ-030 values in the same cycle, and AE is the first byte after release.
REQ-043 SHALL cover clear with OLED_CLEAR_EN defined: clear_req and char_valid high together in READY -> 4*(3+128) bytes sent, the character dropped, cursor 0,0.
